// File: rtl/axi_pkg.sv
// Shared AXI definitions for the slave-side responders: FSM states,
// burst/response encodings and the supported transfer size.
package axi_pkg;

  localparam int AXI_IDS_BITS = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [1:0] FIXED  = 2'b00;
  localparam logic [1:0] INCR   = 2'b01;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  localparam logic [2:0] SIZE_WORD = 3'b010;

  // A burst is unserviceable when it is not word-sized or uses WRAP/reserved.
  function automatic logic attrError(input logic [2:0] size, input logic [1:0] burst);
    return (size != SIZE_WORD) || ((burst != FIXED) && (burst != INCR));
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Burst address/beat tracker shared by the write and read responders.
// Load captures the burst at AW/AR acceptance; step advances one beat.
module axi_burst_addr_gen
  import axi_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic [31:0] i_addr,
  input  logic [3:0]  i_len,
  input  logic [1:0]  i_burst,
  input  logic        i_step,
  output logic [31:0] o_addr,
  output logic        o_last_beat
);

  logic [31:0] r_addr;
  logic [3:0]  r_cnt;
  logic [3:0]  r_len;
  logic        r_incr;

  // Only INCR moves the address; FIXED and illegal burst types hold it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr <= '0;
      r_cnt  <= '0;
      r_len  <= '0;
      r_incr <= 1'b0;
    end else if (i_load) begin
      r_addr <= i_addr;
      r_cnt  <= '0;
      r_len  <= i_len;
      r_incr <= (i_burst == INCR);
    end else if (i_step) begin
      if (r_incr) r_addr <= r_addr + 32'd4;
      r_cnt <= r_cnt + 4'd1;
    end
  end

  assign o_addr      = r_addr;
  assign o_last_beat = (r_cnt == r_len);

endmodule

// File: rtl/axi_write_responder.sv
// AXI slave write responder: accepts one AW burst at a time, writes each
// W beat straight into a word-addressed SRAM port and answers with one B.
module axi_write_responder
  import axi_pkg::*;
#(
  parameter int          MEM_ADDR_BITS = 14,
  parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
  parameter logic [31:0] LIMIT_ADDR    = 32'h0000_FFFF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [AXI_IDS_BITS-1:0]  AWID,
  input  logic [31:0]              AWADDR,
  input  logic [3:0]               AWLEN,
  input  logic [2:0]               AWSIZE,
  input  logic [1:0]               AWBURST,
  input  logic                     AWVALID,
  output logic                     AWREADY,
  input  logic [31:0]              WDATA,
  input  logic [3:0]               WSTRB,
  input  logic                     WLAST,
  input  logic                     WVALID,
  output logic                     WREADY,
  output logic [AXI_IDS_BITS-1:0]  BID,
  output logic [1:0]               BRESP,
  output logic                     BVALID,
  input  logic                     BREADY,
  output logic                     mem_ce,
  output logic [3:0]               mem_we,
  output logic [MEM_ADDR_BITS-1:0] mem_addr,
  output logic [31:0]              mem_din
);

  state_t                  r_state;
  logic                    r_awready;
  logic                    r_wready;
  logic                    r_bvalid;
  logic [1:0]              r_bresp;
  logic [AXI_IDS_BITS-1:0] r_bid;
  logic                    r_err;

  logic        w_aw_hs;
  logic        w_w_hs;
  logic        w_b_hs;
  logic [31:0] w_cur_addr;
  logic        w_last_beat;
  logic        w_in_range;
  logic        w_term;
  logic        w_mismatch;

  assign w_aw_hs = AWVALID & r_awready;
  assign w_w_hs  = WVALID & r_wready;
  assign w_b_hs  = r_bvalid & BREADY;

  axi_burst_addr_gen u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_aw_hs),
    .i_addr     (AWADDR),
    .i_len      (AWLEN),
    .i_burst    (AWBURST),
    .i_step     (w_w_hs),
    .o_addr     (w_cur_addr),
    .o_last_beat(w_last_beat)
  );

  // Offset-from-base compare covers both bounds in one unsigned test.
  assign w_in_range = (w_cur_addr - BASE_ADDR) <= (LIMIT_ADDR - BASE_ADDR);
  assign w_term     = w_w_hs & (WLAST | w_last_beat);
  assign w_mismatch = WLAST ^ w_last_beat;

  // Memory port is driven in the handshake cycle; any earlier error mutes it.
  assign mem_ce   = w_w_hs & w_in_range & ~r_err;
  assign mem_we   = mem_ce ? WSTRB : 4'b0000;
  assign mem_addr = mem_ce ? w_cur_addr[MEM_ADDR_BITS+1:2] : '0;
  assign mem_din  = mem_ce ? WDATA : 32'h0;

  // Responder FSM; all handshake outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= OKAY;
      r_bid     <= '0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_aw_hs) begin
            r_awready <= 1'b0;
            r_wready  <= 1'b1;
            r_bid     <= AWID;
            r_err     <= attrError(AWSIZE, AWBURST);
            r_state   <= DATA;
          end else begin
            r_awready <= 1'b1;
          end
        end
        DATA: begin
          if (w_w_hs) begin
            r_err <= r_err | ~w_in_range | (w_term & w_mismatch);
            if (w_term) begin
              r_wready <= 1'b0;
              r_bvalid <= 1'b1;
              r_bresp  <= (r_err | ~w_in_range | w_mismatch) ? SLVERR : OKAY;
              r_state  <= RESP;
            end
          end
        end
        RESP: begin
          if (w_b_hs) begin
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign AWREADY = r_awready;
  assign WREADY  = r_wready;
  assign BVALID  = r_bvalid;
  assign BRESP   = r_bresp;
  assign BID     = r_bid;

endmodule

// File: tb/tb_axi_write_responder.sv
// Directed scoreboard bench for axi_write_responder.
module tb_axi_write_responder;
  import axi_pkg::*;

  localparam logic [31:0] LIMIT = 32'h0000_FFFF;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [AXI_IDS_BITS-1:0] AWID;
  logic [31:0]             AWADDR;
  logic [3:0]              AWLEN;
  logic [2:0]              AWSIZE;
  logic [1:0]              AWBURST;
  logic                    AWVALID;
  logic                    AWREADY;
  logic [31:0]             WDATA;
  logic [3:0]              WSTRB;
  logic                    WLAST;
  logic                    WVALID;
  logic                    WREADY;
  logic [AXI_IDS_BITS-1:0] BID;
  logic [1:0]              BRESP;
  logic                    BVALID;
  logic                    BREADY;
  logic                    mem_ce;
  logic [3:0]              mem_we;
  logic [13:0]             mem_addr;
  logic [31:0]             mem_din;

  typedef struct {
    logic        ce;
    logic [3:0]  we;
    logic [13:0] addr;
    logic [31:0] din;
  } memExp_t;

  typedef struct {
    logic [AXI_IDS_BITS-1:0] id;
    logic [1:0]              resp;
  } bExp_t;

  memExp_t memQ[$];
  bExp_t   bQ[$];
  int      errors = 0;
  int      checks = 0;

  axi_write_responder #(
    .MEM_ADDR_BITS(14),
    .BASE_ADDR    (32'h0000_0000),
    .LIMIT_ADDR   (LIMIT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .AWID    (AWID),
    .AWADDR  (AWADDR),
    .AWLEN   (AWLEN),
    .AWSIZE  (AWSIZE),
    .AWBURST (AWBURST),
    .AWVALID (AWVALID),
    .AWREADY (AWREADY),
    .WDATA   (WDATA),
    .WSTRB   (WSTRB),
    .WLAST   (WLAST),
    .WVALID  (WVALID),
    .WREADY  (WREADY),
    .BID     (BID),
    .BRESP   (BRESP),
    .BVALID  (BVALID),
    .BREADY  (BREADY),
    .mem_ce  (mem_ce),
    .mem_we  (mem_we),
    .mem_addr(mem_addr),
    .mem_din (mem_din)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Every output at its reset value.
  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_awready"}, AWREADY, 0);
    checkOutput({tag, "_wready"}, WREADY, 0);
    checkOutput({tag, "_bvalid"}, BVALID, 0);
    checkOutput({tag, "_bid"}, BID, 0);
    checkOutput({tag, "_bresp"}, BRESP, OKAY);
    checkOutput({tag, "_mem_ce"}, mem_ce, 0);
    checkOutput({tag, "_mem_we"}, mem_we, 0);
    checkOutput({tag, "_mem_addr"}, mem_addr, 0);
    checkOutput({tag, "_mem_din"}, mem_din, 0);
  endtask

  // One full burst: AW, W beats (optionally with excess beats), B with backpressure.
  task automatic applyStimulus(input string name, input logic [AXI_IDS_BITS-1:0] id,
                               input logic [31:0] addr, input logic [3:0] len,
                               input logic [1:0] burst, input int nbeats, input int lastAt,
                               input logic [3:0] strb, input logic [31:0] dataBase,
                               input int bpCycles);
    logic [31:0] modelAddr;
    logic        modelErr;
    logic        inRange;
    int          term;
    int          waitCnt;
    logic        aw;
    logic        wr;
    memExp_t     me;
    memExp_t     got;
    bExp_t       be;

    modelAddr = addr;
    modelErr  = (burst != FIXED) && (burst != INCR);
    term      = -1;

    AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = SIZE_WORD; AWBURST = burst; AWVALID = 1'b1;
    aw = 1'b0; waitCnt = 0;
    while (!aw && waitCnt < 20) begin
      #2; aw = AWREADY;
      @(posedge clk); #1;
      waitCnt++;
    end
    AWVALID = 1'b0;
    if (!aw) begin
      checkOutput({name, "_aw_timeout"}, aw, 1);
      return;
    end

    for (int i = 0; i < nbeats; i++) begin
      WVALID = 1'b1; WDATA = dataBase + 32'(i); WSTRB = strb; WLAST = (i == lastAt);
      if (term >= 0) begin
        #2;
        checkOutput({name, "_excess_wready"}, WREADY, 0);
        checkOutput({name, "_excess_mem_ce"}, mem_ce, 0);
        break;
      end
      // Base address is zero here, so only the upper bound can be violated.
      inRange = (modelAddr <= LIMIT);
      me.ce   = inRange && !modelErr;
      me.we   = me.ce ? strb : 4'b0000;
      me.addr = me.ce ? modelAddr[15:2] : 14'h0;
      me.din  = me.ce ? WDATA : 32'h0;
      memQ.push_back(me);
      if (!inRange) modelErr = 1'b1;
      if (i == lastAt || i == int'(len)) begin
        term = i;
        if ((i == lastAt) != (i == int'(len))) modelErr = 1'b1;
        be.id = id; be.resp = modelErr ? SLVERR : OKAY;
        bQ.push_back(be);
      end
      if (burst == INCR) modelAddr = modelAddr + 32'd4;

      wr = 1'b0; waitCnt = 0;
      while (!wr && waitCnt < 20) begin
        #2; wr = WREADY;
        if (wr) begin
          got = memQ.pop_front();
          checkOutput($sformatf("%s_b%0d_mem_ce", name, i), mem_ce, got.ce);
          checkOutput($sformatf("%s_b%0d_mem_we", name, i), mem_we, got.we);
          checkOutput($sformatf("%s_b%0d_mem_addr", name, i), mem_addr, got.addr);
          checkOutput($sformatf("%s_b%0d_mem_din", name, i), mem_din, got.din);
        end
        @(posedge clk); #1;
        waitCnt++;
      end
      if (!wr) begin
        checkOutput({name, "_w_timeout"}, wr, 1);
        WVALID = 1'b0;
        return;
      end
      if (term == i) checkOutput({name, "_bvalid_latency"}, BVALID, 1);
    end
    WVALID = 1'b0; WLAST = 1'b0;

    if (bQ.size() == 0) begin
      checkOutput({name, "_no_termination"}, bQ.size(), 1);
      return;
    end
    BREADY = 1'b0;
    for (int c = 0; c < bpCycles; c++) begin
      #2;
      checkOutput($sformatf("%s_hold%0d_bvalid", name, c), BVALID, 1);
      checkOutput($sformatf("%s_hold%0d_bid", name, c), BID, bQ[0].id);
      checkOutput($sformatf("%s_hold%0d_bresp", name, c), BRESP, bQ[0].resp);
      checkOutput($sformatf("%s_hold%0d_awready", name, c), AWREADY, 0);
      @(posedge clk); #1;
    end
    BREADY = 1'b1;
    #2;
    be = bQ.pop_front();
    checkOutput({name, "_bvalid"}, BVALID, 1);
    checkOutput({name, "_bid"}, BID, be.id);
    checkOutput({name, "_bresp"}, BRESP, be.resp);
    @(posedge clk); #1;
    BREADY = 1'b0;
    checkOutput({name, "_bvalid_drop"}, BVALID, 0);
    checkOutput({name, "_awready_back"}, AWREADY, 1);
  endtask

  initial begin
    rst = 1'b1; AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = SIZE_WORD; AWBURST = INCR;
    AWVALID = 1'b0; WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkResetOutputs("reset");
    rst = 1'b0;

    applyStimulus("single", 8'h3C, 32'h0000_0010, 4'd0, INCR, 1, 0, 4'hF, 32'hDEAD_BEEF, 0);
    applyStimulus("incr4", 8'h05, 32'h0000_0100, 4'd3, INCR, 4, 3, 4'hF, 32'h1111_0000, 0);
    applyStimulus("fixed3", 8'h06, 32'h0000_0020, 4'd2, FIXED, 3, 2, 4'b0011, 32'h2222_0000, 5);
    applyStimulus("oor", 8'h07, 32'h0000_FFFC, 4'd1, INCR, 2, 1, 4'hF, 32'h3333_0000, 0);
    applyStimulus("early_last", 8'h08, 32'h0000_0040, 4'd3, INCR, 3, 1, 4'hF, 32'h4444_0000, 0);
    applyStimulus("missing_last", 8'h09, 32'h0000_0060, 4'd1, INCR, 2, -1, 4'hF, 32'h5555_0000, 0);
    applyStimulus("bad_burst", 8'h0A, 32'h0000_0080, 4'd0, 2'b10, 1, 0, 4'hF, 32'h6666_0000, 0);

    // Reset in the middle of a burst: no B may follow.
    AWID = 8'h0B; AWADDR = 32'h0000_0200; AWLEN = 4'd3; AWBURST = INCR; AWVALID = 1'b1;
    #2;
    checkOutput("rstmid_awready", AWREADY, 1);
    @(posedge clk); #1;
    AWVALID = 1'b0;
    WVALID = 1'b1; WDATA = 32'h7777_0000; WSTRB = 4'hF; WLAST = 1'b0;
    #2;
    checkOutput("rstmid_mem_ce", mem_ce, 1);
    checkOutput("rstmid_mem_addr", mem_addr, 14'h080);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checkResetOutputs("rstmid");
    rst = 1'b0; WVALID = 1'b0; BREADY = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #2;
      checkOutput($sformatf("rstmid_no_b%0d", c), BVALID, 0);
      @(posedge clk); #1;
    end
    BREADY = 1'b0;

    applyStimulus("recover", 8'h0C, 32'h0000_0004, 4'd0, INCR, 1, 0, 4'b1000, 32'h8888_0000, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_write_responder.md
Name: axi_write_responder

Overview:
Slave-side AXI write-channel responder. It accepts AW and W bursts from the bridge, drives a word-addressed SRAM write port, and returns one B response per burst. It sits between the bridge slave port (S0/S1) and a memory macro. It is the producer of the BID/BRESP/BVALID traffic that the bridge write-response mux consumes.

Parameters:
MEM_ADDR_BITS, 14, word-address width presented to memory
BASE_ADDR, 32'h0000_0000, lowest legal byte address
LIMIT_ADDR, 32'h0000_FFFF, highest legal byte address; beats outside [BASE_ADDR, LIMIT_ADDR] get SLVERR

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
AWID  in  `AXI_IDS_BITS  write transaction ID
AWADDR  in  32  burst start byte address
AWLEN  in  4  beats-1
AWSIZE  in  3  only 3'b010 supported
AWBURST  in  2  FIXED(00) or INCR(01)
AWVALID  in  1  address valid
AWREADY  out  1  address ready
WDATA  in  32  write data
WSTRB  in  4  byte strobes, active-high
WLAST  in  1  last beat marker
WVALID  in  1  data valid
WREADY  out  1  data ready
BID  out  `AXI_IDS_BITS  echoed AWID
BRESP  out  2  OKAY or SLVERR
BVALID  out  1  response valid
BREADY  in  1  response ready
mem_ce  out  1  memory chip enable, active-high
mem_we  out  4  per-byte write enables, active-high
mem_addr  out  MEM_ADDR_BITS  word address
mem_din  out  32  write data to memory

Behaviour:
- Reset: state=IDLE; AWREADY=0, WREADY=0, BVALID=0, BID=0, BRESP=OKAY, mem_ce=0, mem_we=0, mem_addr=0, mem_din=0; all captured registers cleared. A reset mid-burst abandons the burst and issues no B.
- FSM states: IDLE, DATA, RESP.
- IDLE: AWREADY=1. On AWVALID&AWREADY, capture AWID, AWADDR, AWLEN, AWBURST; clear beat_cnt and err; go to DATA. AWSIZE!=3'b010 or AWBURST not in {00,01} sets err.
- DATA: WREADY=1, AWREADY=0. Each beat is a W handshake (WVALID&WREADY).
  - Legal beat (cur_addr in range and err=0): mem_ce=1, mem_we=WSTRB, mem_din=WDATA, mem_addr=cur_addr[MEM_ADDR_BITS+1:2]. These outputs are combinational from the handshake, so the memory write happens in the same cycle.
  - Out-of-range beat: sets err sticky; mem_ce=0, mem_we=0 for that beat and every later beat of the burst.
  - After each beat: INCR adds 4 to cur_addr (32-bit wrap, no 4KB check); FIXED holds cur_addr. beat_cnt increments.
- Burst end: the beat where WLAST=1 or beat_cnt==AWLEN goes to RESP.
  - If WLAST and (beat_cnt==AWLEN) disagree on that beat, set err.
  - Excess beats after the terminating beat are not accepted (WREADY=0).
- RESP: BVALID=1, BID=captured ID, BRESP = err ? SLVERR(2'b10) : OKAY(2'b00). BID and BRESP stay stable while BVALID=1 and BREADY=0. On BVALID&BREADY go to IDLE; BVALID drops the next cycle.
- Latency:
  - AW accepted cycle 0; first W earliest cycle 1.
  - BVALID rises the cycle after the last W handshake.
  - Next AW is accepted the cycle after the B handshake.
  - Minimum single-beat transaction occupies 3 cycles at full throughput.
- AW and W are never accepted in the same cycle. W presented during IDLE waits.

Decomposition:
- Shared package axi_pkg: state enum (IDLE, DATA, RESP); burst constants FIXED/INCR; resp constants OKAY/SLVERR/DECERR (mirror AXI_define.svh); SIZE_WORD=3'b010.
- Sub-module axi_burst_addr_gen: holds cur_addr and beat_cnt, with load/step inputs and a last_beat output. It is reused by the future read-side responder.

Test Plan:
- Single beat: AWADDR=0x10, AWLEN=0, WSTRB=4'hF, WDATA=0xDEADBEEF, WLAST=1, BREADY=1 -> mem_we=4'hF and mem_addr=4 on W handshake; BVALID next cycle with BID=AWID, BRESP=00.
- INCR 4-beat burst: AWADDR=0x100, AWLEN=3 -> mem_addr 0x40,0x41,0x42,0x43 on consecutive beats; one B with OKAY.
- FIXED 3-beat burst: AWADDR=0x20, WSTRB=4'b0011 -> mem_addr=8 on all beats, mem_we=4'b0011; B OKAY.
- Out of range: LIMIT_ADDR=0xFFFF, AWADDR=0xFFFC, AWLEN=1 -> beat 0 written at word 0x3FFF, beat 1 suppressed (mem_ce=0); BRESP=SLVERR.
- WLAST mismatch: AWLEN=3 with WLAST on beat 1 -> RESP after beat 1 with SLVERR, WREADY=0 afterwards. Separately, AWLEN=1 with WLAST=0 on beat 1 -> SLVERR.
- B backpressure and reset: hold BREADY=0 for 5 cycles -> BVALID, BID and BRESP stable, AWREADY=0; then assert rst mid-DATA -> all outputs return to reset values next edge and no B is issued.
